clk_div_ctrl: RTL and testbench
===============================

CLK_DIV_CTRL -- requirements
Module: clk_div_ctrl

Interface
REQ-001 SHALL have parameter DIV_W, default 8: width of divisor and counter.
REQ-002 SHALL have parameter RESET_DIV, default 3: divisor loaded at reset (legal, 2..2^DIV_W-1).
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-low reset.
REQ-005 SHALL have port en  input  1  level request to run the divided clock.
REQ-006 SHALL have port cfg_valid  input  1  new divisor offered.
REQ-007 SHALL have port cfg_div  input  DIV_W  offered divisor.
REQ-008 SHALL have port cfg_ready  output  1  controller can accept a divisor.
REQ-009 SHALL have port cfg_err  output  1  one-cycle pulse: illegal divisor rejected.
REQ-010 SHALL have port clk_out  output  1  registered divided clock, glitch-free.
REQ-011 SHALL have port tick  output  1  one-cycle pulse on the first clk cycle of each clk_out period.
REQ-012 SHALL have port busy  output  1  high in RUN or DRAIN.
REQ-013 SHALL have port cur_div  output  DIV_W  divisor currently in effect.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DRAIN; all outputs registered.
REQ-015 Period: N = cur_div; counter cnt runs 0..N-1 and wraps; H = (N+1)>>1; clk_out = 1 for cnt in 0..H-1, else 0.
REQ-016 IDLE: clk_out=0, tick=0, cnt=0; en=1 sampled -> next cycle RUN with cnt=0, clk_out=1, tick=1.
REQ-017 RUN: tick=1 exactly when cnt==0; en=0 sampled -> DRAIN, counting continues unchanged.
REQ-018 DRAIN: period SHALL complete (no truncated high/low phase); at cnt==N-1 -> IDLE next cycle.
REQ-019 DRAIN with en=1 sampled -> RUN with no gap, glitch or counter reset.
REQ-020 en falling in the cycle where cnt==N-1 in RUN -> IDLE directly next cycle.
REQ-021 cfg handshake: transfer when cfg_valid && cfg_ready.
REQ-022 Legal divisor (cfg_div >= 2) transferred -> stored as pending; cfg_ready=0 from next cycle.
REQ-023 Illegal divisor (0 or 1) transferred -> discarded; cfg_err=1 next cycle only; cfg_ready stays 1; cur_div unchanged.
REQ-024 Pending apply in RUN/DRAIN: on the edge leaving cnt==N-1, cur_div <= pending and the new period uses the new N and H.
REQ-025 Pending apply in IDLE: cur_div <= pending on the next edge.
REQ-026 cfg_ready SHALL return to 1 in the cycle after the pending divisor is applied.
REQ-027 Start and apply on the same edge (IDLE, en=1, pending present): the first period SHALL use the new divisor.
REQ-028 busy = 1 in RUN or DRAIN, 0 in IDLE.
REQ-029 cnt SHALL never exceed N-1; no divisor change SHALL occur mid-period.

Reset
REQ-030 rst=0 sampled -> next cycle: IDLE, cnt=0, clk_out=0, tick=0, busy=0, cfg_ready=1, cfg_err=0, pending cleared, cur_div=RESET_DIV.
REQ-031 Reset SHALL dominate all inputs and SHALL abort any period in progress, including mid-high phase.
REQ-032 Outputs SHALL hold their reset values for as long as rst=0.

Verification
REQ-033 Reset, en=1, cur_div=3 -> clk_out 1,1,0 repeating; tick every 3rd cycle aligned with the first 1.
REQ-034 Offer cfg_div=4 mid-period at N=3 -> cfg_ready drops; current 3-cycle period completes; then clk_out 1,1,0,0 repeating; cur_div=4; cfg_ready=1 the cycle after apply.
REQ-035 Offer cfg_div=1, then cfg_div=0 -> each gives a single cfg_err pulse; cur_div and clk_out unchanged; cfg_ready stays 1.
REQ-036 N=5, drop en at cnt=1 -> clk_out finishes 1,1,1,0,0 and then stays 0; busy falls after cnt=4; re-raise en at cnt=3 instead -> continuous output with no gap.
REQ-037 In IDLE, load cfg_div=2, then en=1 -> first period is 1,0 with tick on the first cycle.
REQ-038 Assert rst=0 during a high phase at N=6 -> next cycle clk_out=0, busy=0, cur_div=3, cfg_ready=1.

Source files
------------

// File: rtl/clk_div_ctrl.sv
// Programmable clock divider: registered glitch-free clk_out with tick, divisor updates only at period boundaries.
// One-cycle latency from en/cfg to outputs; cfg_ready stays low while a divisor is pending.
module clk_div_ctrl #(
  parameter int DIV_W     = 8,
  parameter int RESET_DIV = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             clk_out,
  output logic             tick,
  output logic             busy,
  output logic [DIV_W-1:0] cur_div
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t           state, nxt_state;
  logic [DIV_W-1:0] cnt, nxt_cnt;
  logic [DIV_W-1:0] pend_div, nd;
  logic             pend_vld;
  logic             last, apply;
  logic [DIV_W:0]   half;

  assign last = (cnt == cur_div - DIV_W'(1));

  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    apply     = 1'b0;
    case (state)
      IDLE: begin
        apply   = pend_vld;
        nxt_cnt = '0;
        if (en) nxt_state = RUN;
      end
      RUN: begin
        apply   = last && pend_vld;
        nxt_cnt = last ? '0 : cnt + DIV_W'(1);
        if (!en) nxt_state = last ? IDLE : DRAIN;
      end
      DRAIN: begin
        apply   = last && pend_vld;
        nxt_cnt = last ? '0 : cnt + DIV_W'(1);
        if (en)        nxt_state = RUN;
        else if (last) nxt_state = IDLE;
      end
      default: nxt_state = IDLE;
    endcase
    if (nxt_state == IDLE) nxt_cnt = '0;
    // The period that starts on this edge must already use the divisor being applied.
    nd   = apply ? pend_div : cur_div;
    half = ({1'b0, nd} + (DIV_W+1)'(1)) >> 1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      clk_out   <= 1'b0;
      tick      <= 1'b0;
      busy      <= 1'b0;
      cfg_ready <= 1'b1;
      cfg_err   <= 1'b0;
      pend_vld  <= 1'b0;
      pend_div  <= '0;
      cur_div   <= DIV_W'(RESET_DIV);
    end else begin
      state   <= nxt_state;
      cnt     <= nxt_cnt;
      clk_out <= (nxt_state != IDLE) && ({1'b0, nxt_cnt} < half);
      tick    <= (nxt_state != IDLE) && (nxt_cnt == '0);
      busy    <= (nxt_state != IDLE);
      cfg_err <= 1'b0;
      if (cfg_valid && cfg_ready) begin
        if (cfg_div >= DIV_W'(2)) begin
          pend_div  <= cfg_div;
          pend_vld  <= 1'b1;
          cfg_ready <= 1'b0;
        end else begin
          cfg_err <= 1'b1;
        end
      end
      if (apply) begin
        cur_div   <= pend_div;
        pend_vld  <= 1'b0;
        cfg_ready <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Bench for clk_div_ctrl: directed scenarios plus randomized traffic against a period-queue model.
module tb_clk_div_ctrl;
  localparam int DIV_W = 8;
  localparam int RESET_DIV = 3;

  logic clk, rst, en, cfg_valid;
  logic [DIV_W-1:0] cfg_div;
  logic cfg_ready, cfg_err, clk_out, tick, busy;
  logic [DIV_W-1:0] cur_div;

  int n_cmp = 0;
  int n_bad = 0;

  clk_div_ctrl #(.DIV_W(DIV_W), .RESET_DIV(RESET_DIV)) dut (
    .clk(clk), .rst(rst), .en(en), .cfg_valid(cfg_valid), .cfg_div(cfg_div),
    .cfg_ready(cfg_ready), .cfg_err(cfg_err), .clk_out(clk_out), .tick(tick),
    .busy(busy), .cur_div(cur_div)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: a period is a queue of clk_out levels still to be shown; a new one
  // starts only when idle or when the last level of the current one is showing.
  bit m_q[$];
  bit m_act, m_clk, m_tick, m_err, m_ready, m_pv;
  int m_cur, m_pend, m_cnt;

  task automatic model_edge();
    bit last, ap, start, rdy0;
    int nd;
    if (!rst) begin
      m_q.delete();
      m_act = 0; m_clk = 0; m_tick = 0; m_err = 0; m_ready = 1; m_pv = 0;
      m_cur = RESET_DIV; m_cnt = 0;
      return;
    end
    last  = m_act && (m_q.size() == 0);
    ap    = m_pv && (!m_act || last);
    start = en && (!m_act || last);
    rdy0  = m_ready;
    nd    = ap ? m_pend : m_cur;
    m_err = 0;
    if (ap) begin m_cur = m_pend; m_pv = 0; m_ready = 1; end
    if (cfg_valid && rdy0) begin
      if (cfg_div >= 2) begin m_pend = cfg_div; m_pv = 1; m_ready = 0; end
      else m_err = 1;
    end
    m_tick = 0;
    if (start) begin
      m_q.delete();
      for (int i = 0; i < nd; i++) m_q.push_back(i < (nd + 1) / 2);
      m_act = 1; m_cnt = 0; m_tick = 1;
      m_clk = m_q.pop_front();
    end else if (!m_act || last) begin
      m_act = 0; m_clk = 0; m_cnt = 0;
    end else begin
      m_clk = m_q.pop_front();
      m_cnt++;
    end
  endtask

  function automatic logic [12:0] expv();
    return {m_clk, m_tick, m_act, m_ready, m_err, 8'(m_cur)};
  endfunction

  function automatic logic [12:0] gotv();
    return {clk_out, tick, busy, cfg_ready, cfg_err, cur_div};
  endfunction

  task automatic cyc(input logic e, input logic v, input logic [7:0] d, input logic r);
    en = e; cfg_valid = v; cfg_div = d; rst = r;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b1, 8'd5, 1'b0);
      n_cmp++;
      if (gotv() !== 13'b0_0_0_1_0_00000011) begin
        n_bad++; $display("FAIL reset_const[%0d]: got %b want %b", i, gotv(), 13'b0_0_0_1_0_00000011);
      end
    end
    cyc(1'b0, 1'b0, 8'd0, 1'b1);
    n_cmp++;
    if (gotv() !== expv()) begin n_bad++; $display("FAIL reset_idle: got %b want %b", gotv(), expv()); end
  endtask

  task automatic test_div3();
    for (int i = 0; i < 9; i++) begin
      cyc(1'b1, 1'b0, 8'd0, 1'b1);
      n_cmp++;
      if ({clk_out, tick} !== {(i % 3) != 2, (i % 3) == 0}) begin
        n_bad++; $display("FAIL div3[%0d]: got clk/tick %b%b want %b%b", i, clk_out, tick, (i % 3) != 2, (i % 3) == 0);
      end
      n_cmp++;
      if (gotv() !== expv()) begin n_bad++; $display("FAIL div3_model[%0d]: got %b want %b", i, gotv(), expv()); end
    end
  endtask

  task automatic test_cfg_change();
    cyc(1'b1, 1'b0, 8'd0, 1'b1);
    cyc(1'b1, 1'b1, 8'd4, 1'b1);
    n_cmp++;
    if (cfg_ready !== 1'b0) begin n_bad++; $display("FAIL cfg4_ready_drop: got %b want 0", cfg_ready); end
    for (int k = 0; k < 10 && m_cur != 4; k++) begin
      cyc(1'b1, 1'b0, 8'd0, 1'b1);
      n_cmp++;
      if (gotv() !== expv()) begin n_bad++; $display("FAIL cfg4_wait: got %b want %b", gotv(), expv()); end
    end
    n_cmp++;
    if (cur_div !== 8'd4 || cfg_ready !== 1'b1 || m_cur != 4) begin
      n_bad++; $display("FAIL cfg4_apply: got div %0d rdy %b want div 4 rdy 1", cur_div, cfg_ready);
    end
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (clk_out !== ((i % 4) < 2)) begin n_bad++; $display("FAIL cfg4_wave[%0d]: got %b want %b", i, clk_out, (i % 4) < 2); end
      cyc(1'b1, 1'b0, 8'd0, 1'b1);
    end
  endtask

  task automatic test_illegal();
    logic [7:0] bad_div [2];
    bad_div[0] = 8'd1; bad_div[1] = 8'd0;
    for (int j = 0; j < 2; j++) begin
      cyc(1'b1, 1'b1, bad_div[j], 1'b1);
      n_cmp++;
      if ({cfg_err, cfg_ready, cur_div} !== {1'b1, 1'b1, 8'd4}) begin
        n_bad++; $display("FAIL illegal_%0d: got err/rdy/div %b/%b/%0d want 1/1/4", bad_div[j], cfg_err, cfg_ready, cur_div);
      end
      n_cmp++;
      if (gotv() !== expv()) begin n_bad++; $display("FAIL illegal_model: got %b want %b", gotv(), expv()); end
      cyc(1'b1, 1'b0, 8'd0, 1'b1);
      n_cmp++;
      if (cfg_err !== 1'b0) begin n_bad++; $display("FAIL illegal_pulse: got %b want 0", cfg_err); end
    end
  endtask

  task automatic test_drain();
    logic [2:0] tail;
    logic [6:0] cont;
    tail = 3'b100;
    cont = 7'b0111001;
    cyc(1'b1, 1'b1, 8'd5, 1'b1);
    for (int k = 0; k < 20 && !(m_cur == 5 && m_act && m_cnt == 1); k++) begin
      cyc(1'b1, 1'b0, 8'd0, 1'b1);
      n_cmp++;
      if (gotv() !== expv()) begin n_bad++; $display("FAIL drain_wait: got %b want %b", gotv(), expv()); end
    end
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 8'd0, 1'b1);
      n_cmp++;
      if ({clk_out, busy} !== {tail[2-i], 1'b1}) begin
        n_bad++; $display("FAIL drain_tail[%0d]: got clk/busy %b%b want %b1", i, clk_out, busy, tail[2-i]);
      end
    end
    cyc(1'b0, 1'b0, 8'd0, 1'b1);
    n_cmp++;
    if ({clk_out, busy, tick} !== 3'b000) begin n_bad++; $display("FAIL drain_idle: got %b%b%b want 000", clk_out, busy, tick); end
    for (int k = 0; k < 3 && !(m_act && m_cnt == 1); k++) cyc(1'b1, 1'b0, 8'd0, 1'b1);
    cyc(1'b0, 1'b0, 8'd0, 1'b1);
    cyc(1'b0, 1'b0, 8'd0, 1'b1);
    for (int i = 0; i < 7; i++) begin
      cyc(1'b1, 1'b0, 8'd0, 1'b1);
      n_cmp++;
      if ({clk_out, busy} !== {cont[6-i], 1'b1}) begin
        n_bad++; $display("FAIL drain_resume[%0d]: got clk/busy %b%b want %b1", i, clk_out, busy, cont[6-i]);
      end
      n_cmp++;
      if (gotv() !== expv()) begin n_bad++; $display("FAIL drain_model: got %b want %b", gotv(), expv()); end
    end
  endtask

  task automatic test_idle_load();
    for (int k = 0; k < 10 && m_act; k++) cyc(1'b0, 1'b0, 8'd0, 1'b1);
    cyc(1'b0, 1'b1, 8'd2, 1'b1);
    n_cmp++;
    if ({cfg_ready, busy} !== 2'b00) begin n_bad++; $display("FAIL idle2_xfer: got rdy/busy %b%b want 00", cfg_ready, busy); end
    cyc(1'b0, 1'b0, 8'd0, 1'b1);
    n_cmp++;
    if ({cur_div, cfg_ready} !== {8'd2, 1'b1}) begin n_bad++; $display("FAIL idle2_apply: got %0d/%b want 2/1", cur_div, cfg_ready); end
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b0, 8'd0, 1'b1);
      n_cmp++;
      if ({clk_out, tick} !== {(i % 2) == 0, (i % 2) == 0}) begin
        n_bad++; $display("FAIL idle2_wave[%0d]: got %b%b want %b%b", i, clk_out, tick, (i % 2) == 0, (i % 2) == 0);
      end
    end
    for (int k = 0; k < 10 && m_act; k++) cyc(1'b0, 1'b0, 8'd0, 1'b1);
    cyc(1'b0, 1'b1, 8'd3, 1'b1);
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, 1'b0, 8'd0, 1'b1);
      n_cmp++;
      if ({cur_div, clk_out, tick} !== {8'd3, (i % 3) != 2, (i % 3) == 0}) begin
        n_bad++; $display("FAIL same_edge[%0d]: got %0d/%b%b want 3/%b%b", i, cur_div, clk_out, tick, (i % 3) != 2, (i % 3) == 0);
      end
    end
  endtask

  task automatic test_reset_mid();
    cyc(1'b1, 1'b1, 8'd6, 1'b1);
    for (int k = 0; k < 20 && !(m_cur == 6 && m_act && m_cnt == 1); k++) cyc(1'b1, 1'b0, 8'd0, 1'b1);
    n_cmp++;
    if (clk_out !== 1'b1) begin n_bad++; $display("FAIL rstmid_high: got %b want 1", clk_out); end
    for (int i = 0; i < 2; i++) begin
      cyc(1'b1, 1'b1, 8'd9, 1'b0);
      n_cmp++;
      if ({clk_out, tick, busy, cfg_ready, cfg_err, cur_div} !== {5'b00010, 8'd3}) begin
        n_bad++; $display("FAIL rstmid[%0d]: got %b want %b", i, gotv(), {5'b00010, 8'd3});
      end
    end
    cyc(1'b0, 1'b0, 8'd0, 1'b1);
  endtask

  task automatic test_random();
    logic e, v, r;
    logic [7:0] d;
    e = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7) == 0) e = ~e;
      v = ($urandom_range(3) == 0);
      d = ($urandom_range(2) == 0) ? 8'($urandom_range(3)) : 8'($urandom_range(12, 2));
      r = ($urandom_range(199) != 0);
      cyc(e, v, d, r);
      n_cmp++;
      if (gotv() !== expv()) begin n_bad++; $display("FAIL random[%0d]: got %b want %b", i, gotv(), expv()); end
    end
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; cfg_valid = 1'b0; cfg_div = '0;
    test_reset();
    test_div3();
    test_cfg_change();
    test_illegal();
    test_drain();
    test_idle_load();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
